viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, K=3 (generators 7,5 octal) convolutional code used on the encode path. It sits directly downstream of the serial-to-parallel stage: it consumes the recovered 2-bit symbols (`parallel_encode_noise_sig`) at the 10 MHz symbol rate and produces the decoded bit stream (`decode_sig`). Survivors are held by register exchange, and path metrics are renormalised every symbol.

---
 rtl/viterbi_decoder_if.sv | 29 ++
 rtl/viterbi_decoder.sv | 134 +++++++++++++
 tb/tb_viterbi_decoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_decoder_if.sv
// ---------------------------------------------------------------------------
// viterbi_decoder_if
//   Symbol/decoded-bit bundle between the serial-to-parallel stage (master)
//   and the hard-decision Viterbi decoder (slave).
//
//   sym_sig           2  received symbol, [1] = G0 (111) bit, [0] = G1 (101) bit
//   sym_valid_sig     1  symbol accepted on a rising edge where this is 1
//   decode_sig        1  decoded bit (registered)
//   decode_valid_sig  1  decode_sig is valid this cycle
//   pm_min_state_sig  2  best trellis state after the last accepted symbol
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface viterbi_decoder_if;
  logic [1:0] sym_sig;
  logic       sym_valid_sig;
  logic       decode_sig;
  logic       decode_valid_sig;
  logic [1:0] pm_min_state_sig;

  modport master (
    output sym_sig, sym_valid_sig,
    input  decode_sig, decode_valid_sig, pm_min_state_sig
  );

  modport slave (
    input  sym_sig, sym_valid_sig,
    output decode_sig, decode_valid_sig, pm_min_state_sig
  );
endinterface

// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal)
//   convolutional code. Register-exchange survivors of TB_DEPTH bits, path
//   metrics renormalised on every accepted symbol so the best metric is 0.
//
//   Parameters
//     TB_DEPTH  survivor length / decision depth in symbols (4..64)
//     PM_W      path-metric width in bits (>= 4)
//
//   Ports
//     clk10M_sig  in   symbol-rate clock, the only clock
//     reset_sig   in   asynchronous active-low reset
//     bus         slave modport of viterbi_decoder_if (symbol in, bit out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic              clk10M_sig,
  input  logic              reset_sig,
  viterbi_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  // Non-zero start states carry a large penalty so decoding begins in 00.
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(2 ** (PM_W - 2));

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                decode_q, decode_d;
  logic                valid_q, valid_d;
  logic [1:0]          best_q, best_d;

  // Hamming distance between the received symbol and the symbol the encoder
  // would emit from state s with input u.
  function automatic logic [1:0] branchMetric(input logic [1:0] sym,
                                              input logic [1:0] s,
                                              input logic       u);
    logic [1:0] expSym;
    logic [1:0] diff;
    expSym = {u ^ s[1] ^ s[0], u ^ s[0]};
    diff   = sym ^ expSym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Add-compare-select for all four next states, renormalisation, best-state
  // selection and the symbol counter. Everything holds when no symbol is
  // offered; only the valid strobe drops.
  always_comb begin
    logic [PM_W-1:0]     win     [4];
    logic [TB_DEPTH-1:0] survNew [4];
    logic [PM_W-1:0]     cand0, cand1, minWin;
    logic [1:0]          nsIdx, p0, p1, bestSel;

    for (int i = 0; i < 4; i++) begin
      pm_d[i]   = pm_q[i];
      surv_d[i] = surv_q[i];
    end
    cnt_d    = cnt_q;
    decode_d = decode_q;
    best_d   = best_q;
    valid_d  = 1'b0;

    // Next state {u, a} is reached from {a, 0} or {a, 1}; ties go to {a, 0}.
    for (int ns = 0; ns < 4; ns++) begin
      nsIdx = 2'(ns);
      p0    = {nsIdx[0], 1'b0};
      p1    = {nsIdx[0], 1'b1};
      cand0 = pm_q[p0] + PM_W'(branchMetric(bus.sym_sig, p0, nsIdx[1]));
      cand1 = pm_q[p1] + PM_W'(branchMetric(bus.sym_sig, p1, nsIdx[1]));
      if (cand0 <= cand1) begin
        win[ns]     = cand0;
        survNew[ns] = {surv_q[p0][TB_DEPTH-2:0], nsIdx[1]};
      end else begin
        win[ns]     = cand1;
        survNew[ns] = {surv_q[p1][TB_DEPTH-2:0], nsIdx[1]};
      end
    end

    // Strict compare keeps the lowest index on equal metrics.
    minWin  = win[0];
    bestSel = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (win[i] < minWin) begin
        minWin  = win[i];
        bestSel = 2'(i);
      end
    end

    if (bus.sym_valid_sig) begin
      for (int i = 0; i < 4; i++) begin
        pm_d[i]   = win[i] - minWin;
        surv_d[i] = survNew[i];
      end
      cnt_d    = (cnt_q == CNT_W'(TB_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
      decode_d = survNew[bestSel][TB_DEPTH-1];
      best_d   = bestSel;
      valid_d  = (cnt_d == CNT_W'(TB_DEPTH));
    end
  end

  // State registers; reset forces the trellis to start from state 00.
  always_ff @(posedge clk10M_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
      cnt_q    <= '0;
      decode_q <= 1'b0;
      valid_q  <= 1'b0;
      best_q   <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      cnt_q    <= cnt_d;
      decode_q <= decode_d;
      valid_q  <= valid_d;
      best_q   <= best_d;
    end
  end

  assign bus.decode_sig       = decode_q;
  assign bus.decode_valid_sig = valid_q;
  assign bus.pm_min_state_sig = best_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder
//   Scoreboard bench for viterbi_decoder. The driver encodes source bits,
//   runs a forward-relaxation Viterbi model with unbounded integer metrics
//   and full-length path bit arrays, and queues one expectation per accepted
//   symbol. A negedge monitor pops and compares, and checks hold behaviour
//   on cycles without an accepted symbol.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 6;

  typedef struct {
    int         cycle;
    logic       hasOut;
    logic       dec;
    logic [1:0] best;
    logic       strict;
    logic       soak;
    logic       src;
  } expT;

  logic clk10M_sig = 1'b0;
  logic reset_sig  = 1'b1;

  viterbi_decoder_if bus ();

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk10M_sig (clk10M_sig),
    .reset_sig  (reset_sig),
    .bus        (bus)
  );

  expT  expQ[$];
  bit   stimBits[$];
  bit   srcHist[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;
  int   soakBitErrs = 0;
  bit   inReset = 1'b1;
  bit   monitorOn = 1'b0;
  logic heldDec = 1'b0;
  logic [1:0] heldBest = 2'd0;
  bit   enc1 = 1'b0;
  bit   enc2 = 1'b0;

  // Reference model state: raw path metrics and path bits (index 0 = oldest).
  int refPm [4];
  bit refHist [4][TB_DEPTH];
  int refCnt;

  // 10 MHz symbol clock.
  always #50 clk10M_sig = ~clk10M_sig;

  // Cycle index used to tie each expectation to the edge that accepts it.
  always @(posedge clk10M_sig) cycleNo <= cycleNo + 1;

  // Global time limit so the run always ends.
  initial begin
    #20000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int minOf4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // Start the model from state 00 with the other states heavily penalised.
  task automatic modelReset();
    for (int s = 0; s < 4; s++) begin
      refPm[s] = (s == 0) ? 0 : (1 << (PM_W - 2));
      for (int k = 0; k < TB_DEPTH; k++) refHist[s][k] = 1'b0;
    end
    refCnt = 0;
  endtask

  // Forward relaxation over every (state, input) transition. Visiting states
  // in ascending order with a strict compare gives ties to the lower state.
  task automatic modelStep(input logic [1:0] sym, output logic dec, output logic [1:0] best, output logic hasOut);
    int newPm [4];
    bit newHist [4][TB_DEPTH];
    int bestIdx;
    for (int ns = 0; ns < 4; ns++) newPm[ns] = 1 << 30;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        int ns, g0, g1, cand;
        ns   = u * 2 + s / 2;
        g0   = u ^ (s / 2) ^ (s % 2);
        g1   = u ^ (s % 2);
        cand = refPm[s] + ((g0 != int'(sym[1])) ? 1 : 0) + ((g1 != int'(sym[0])) ? 1 : 0);
        if (cand < newPm[ns]) begin
          newPm[ns] = cand;
          for (int k = 0; k < TB_DEPTH - 1; k++) newHist[ns][k] = refHist[s][k + 1];
          newHist[ns][TB_DEPTH - 1] = bit'(u);
        end
      end
    end
    bestIdx = 0;
    for (int s = 1; s < 4; s++) if (newPm[s] < newPm[bestIdx]) bestIdx = s;
    refPm   = newPm;
    refHist = newHist;
    if (refCnt < TB_DEPTH) refCnt++;
    dec    = newHist[bestIdx][0];
    best   = 2'(bestIdx);
    hasOut = (refCnt >= TB_DEPTH);
  endtask

  // Reference (7,5) encoder.
  task automatic encodeBit(input bit u, output logic [1:0] sym);
    sym  = {u ^ enc1 ^ enc2, u ^ enc2};
    enc2 = enc1;
    enc1 = u;
  endtask

  // Drive one cycle of input; for an offered symbol, queue its expectation.
  task automatic applyStimulus(input logic valid, input logic [1:0] sym, input bit srcBit,
                               input logic strict, input logic soak);
    expT e;
    @(posedge clk10M_sig);
    #1;
    bus.sym_valid_sig = valid;
    bus.sym_sig       = sym;
    if (valid) begin
      modelStep(sym, e.dec, e.best, e.hasOut);
      srcHist.push_back(srcBit);
      e.src    = e.hasOut ? srcHist[srcHist.size() - TB_DEPTH] : 1'b0;
      e.cycle  = cycleNo + 1;
      e.strict = strict;
      e.soak   = soak;
      expQ.push_back(e);
    end
  endtask

  // Pulse the asynchronous reset low for the given number of cycles.
  task automatic applyReset(input int cycles);
    @(posedge clk10M_sig);
    #1;
    bus.sym_valid_sig = 1'b0;
    @(negedge clk10M_sig);
    #1;
    inReset   = 1'b1;
    reset_sig = 1'b0;
    #1;
    checkOutput("resetValid", bus.decode_valid_sig, 0);
    checkOutput("resetDecode", bus.decode_sig, 0);
    checkOutput("resetBest", bus.pm_min_state_sig, 0);
    repeat (cycles) @(posedge clk10M_sig);
    #1;
    checkOutput("resetHeldValid", bus.decode_valid_sig, 0);
    reset_sig = 1'b1;
    modelReset();
    expQ.delete();
    srcHist.delete();
    enc1      = 1'b0;
    enc2      = 1'b0;
    heldDec   = 1'b0;
    heldBest  = 2'd0;
    inReset   = 1'b0;
    monitorOn = 1'b1;
  endtask

  // Encode stimBits and feed them. gapMode: 0 none, 1 toggle, 2 random gaps.
  task automatic runStream(input int gapMode, input int corruptIdx, input logic strict,
                           input logic soak, input bit noise, input bit drain);
    int lastFlip;
    lastFlip = -100;
    for (int i = 0; i < stimBits.size(); i++) begin
      logic [1:0] sym;
      encodeBit(stimBits[i], sym);
      if (i == corruptIdx) sym = 2'b10;
      if (noise) begin
        for (int b = 0; b < 2; b++) begin
          if ($urandom_range(99) == 0 && (i - lastFlip) >= 8) begin
            sym[b]   = ~sym[b];
            lastFlip = i;
          end
        end
      end
      applyStimulus(1'b1, sym, stimBits[i], strict, soak);
      if (gapMode == 1 || (gapMode == 2 && $urandom_range(9) == 0))
        applyStimulus(1'b0, 2'($urandom), 1'b0, 1'b0, 1'b0);
    end
    if (drain) begin
      applyStimulus(1'b0, 2'($urandom), 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 50 && expQ.size() != 0; w++) @(negedge clk10M_sig);
      checkOutput("drained", expQ.size(), 0);
    end
  endtask

  task automatic loadClean();
    stimBits = '{1, 0, 1, 1, 0, 0};
    repeat (TB_DEPTH) stimBits.push_back(1'b0);
  endtask

  task automatic loadRandom(input int n, input bit tail);
    stimBits.delete();
    repeat (n) stimBits.push_back(bit'($urandom_range(1)));
    if (tail) repeat (TB_DEPTH) stimBits.push_back(1'b0);
  endtask

  // Monitor: compare each accepted symbol's result in the cycle after its
  // acceptance edge; on other cycles outputs must hold and valid must be low.
  always @(negedge clk10M_sig) begin
    if (monitorOn && !inReset) begin
      if (expQ.size() > 0 && expQ[0].cycle == cycleNo) begin
        expT e;
        e = expQ.pop_front();
        checkOutput("decodeValid", bus.decode_valid_sig, e.hasOut);
        checkOutput("decodeBit", bus.decode_sig, e.dec);
        checkOutput("bestState", bus.pm_min_state_sig, e.best);
        checkOutput("pmMinZero", minOf4(int'(dut.pm_q[0]), int'(dut.pm_q[1]),
                                        int'(dut.pm_q[2]), int'(dut.pm_q[3])), 0);
        if (e.hasOut && e.strict) checkOutput("decodeVsSource", bus.decode_sig, e.src);
        if (e.hasOut && e.soak && bus.decode_sig !== e.src) soakBitErrs++;
        heldDec  = e.dec;
        heldBest = e.best;
      end else begin
        checkOutput("idleValidLow", bus.decode_valid_sig, 0);
        checkOutput("holdDecode", bus.decode_sig, heldDec);
        checkOutput("holdBest", bus.pm_min_state_sig, heldBest);
      end
    end
  end

  // Test sequence.
  initial begin
    bus.sym_valid_sig = 1'b0;
    bus.sym_sig       = 2'b00;
    modelReset();

    $display("[TB] reset and idle");
    applyReset(2);
    repeat (10) applyStimulus(1'b0, 2'($urandom), 1'b0, 1'b0, 1'b0);

    $display("[TB] clean stream");
    loadClean();
    runStream(0, -1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] single symbol error");
    applyReset(1);
    loadClean();
    runStream(0, 2, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] gapped input");
    applyReset(1);
    loadClean();
    runStream(1, -1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] mid-stream reset");
    applyReset(1);
    loadRandom(20, 1'b0);
    runStream(0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyReset(1);
    loadRandom(30, 1'b1);
    runStream(0, -1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] random soak");
    applyReset(1);
    soakBitErrs = 0;
    loadRandom(4000, 1'b1);
    runStream(2, -1, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("soakBitErrorsOverTwo", (soakBitErrs > 2) ? 1 : 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
